// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and the write-queue entry type
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } entry_t;
endpackage

// File: rtl/wbq_fifo.sv
// wbq_fifo: in-order entry storage with wrapping pointers and an occupancy count
module wbq_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  entry_t               din,
    output entry_t [DEPTH-1:0]   mem,
    output logic   [PW-1:0]      rd_ptr,
    output logic   [CW-1:0]      count,
    output logic                 full,
    output logic                 empty
);
    logic [PW-1:0] wr_ptr;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // payload storage needs no reset; validity comes from the count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: buffers writeback requests and drains them onto the register file write port with forwarding
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            InValid,
    output logic                            InReady,
    input  logic [REG_ADDR_W-1:0]           InRegister,
    input  logic [DATA_W-1:0]               InData,
    input  logic                            Pause,
    output logic [REG_ADDR_W-1:0]           WriteRegister,
    output logic [DATA_W-1:0]               WriteData,
    output logic                            RegWrite,
    input  logic [REG_ADDR_W-1:0]           LookupReg1,
    input  logic [REG_ADDR_W-1:0]           LookupReg2,
    output logic                            FwdHit1,
    output logic                            FwdHit2,
    output logic [DATA_W-1:0]               FwdData1,
    output logic [DATA_W-1:0]               FwdData2,
    output logic [$clog2(DEPTH+1)-1:0]      Count,
    output logic                            Empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    entry_t [DEPTH-1:0] mem;
    entry_t din, head;
    logic [PW-1:0] rd_ptr;
    logic full, push, pop;
    assign InReady = !full;
    assign push = InValid && InReady && InRegister != ZERO_REG;
    assign pop = RegWrite;
    assign din = '{addr: InRegister, data: InData};
    assign head = mem[rd_ptr];
    assign RegWrite = !Empty && !Pause;
    assign WriteRegister = Empty ? ZERO_REG : head.addr;
    assign WriteData = Empty ? '0 : head.data;
    wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(Clk),
        .rst_n(Reset_n),
        .push(push),
        .pop(pop),
        .din(din),
        .mem(mem),
        .rd_ptr(rd_ptr),
        .count(Count),
        .full(full),
        .empty(Empty)
    );
    // scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        FwdHit1 = 1'b0;
        FwdHit2 = 1'b0;
        FwdData1 = '0;
        FwdData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < Count && LookupReg1 != ZERO_REG && mem[rd_ptr + PW'(i)].addr == LookupReg1) begin
                FwdHit1 = 1'b1;
                FwdData1 = mem[rd_ptr + PW'(i)].data;
            end
            if (CW'(i) < Count && LookupReg2 != ZERO_REG && mem[rd_ptr + PW'(i)].addr == LookupReg2) begin
                FwdHit2 = 1'b1;
                FwdData2 = mem[rd_ptr + PW'(i)].data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed and randomized checks against a queue-based reference model
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];
    int passed = 0;
    int total = 0;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic InValid = 1'b0;
    logic InReady;
    logic [4:0] InRegister = '0;
    logic [31:0] InData = '0;
    logic Pause = 1'b0;
    logic [4:0] WriteRegister;
    logic [31:0] WriteData;
    logic RegWrite;
    logic [4:0] LookupReg1 = '0;
    logic [4:0] LookupReg2 = '0;
    logic FwdHit1, FwdHit2;
    logic [31:0] FwdData1, FwdData2;
    logic [2:0] Count;
    logic Empty;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .InRegister(InRegister), .InData(InData), .Pause(Pause),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .LookupReg1(LookupReg1), .LookupReg2(LookupReg2),
        .FwdHit1(FwdHit1), .FwdHit2(FwdHit2), .FwdData1(FwdData1), .FwdData2(FwdData2),
        .Count(Count), .Empty(Empty)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model();
        logic h1, h2;
        logic [31:0] d1, d2;
        int n;
        n = q.size();
        h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
        foreach (q[i]) begin
            if (q[i].r != 0 && q[i].r == LookupReg1) begin h1 = 1'b1; d1 = q[i].d; end
            if (q[i].r != 0 && q[i].r == LookupReg2) begin h2 = 1'b1; d2 = q[i].d; end
        end
        chk("count", 32'(Count), 32'(n));
        chk("empty", 32'(Empty), 32'(n == 0));
        chk("in_ready", 32'(InReady), 32'(n < DEPTH));
        chk("reg_write", 32'(RegWrite), 32'(n != 0 && !Pause));
        chk("write_register", 32'(WriteRegister), n != 0 ? 32'(q[0].r) : 32'd0);
        chk("write_data", WriteData, n != 0 ? q[0].d : 32'd0);
        chk("fwd_hit1", 32'(FwdHit1), 32'(h1));
        chk("fwd_data1", FwdData1, d1);
        chk("fwd_hit2", 32'(FwdHit2), 32'(h2));
        chk("fwd_data2", FwdData2, d2);
    endtask

    // apply inputs just after a falling edge, check, advance the model across the rising edge
    task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d, input logic p,
                        input logic [4:0] l1, input logic [4:0] l2);
        logic acc, pp;
        InValid = v; InRegister = r; InData = d; Pause = p; LookupReg1 = l1; LookupReg2 = l2;
        #1;
        check_model();
        acc = v && q.size() < DEPTH;
        pp = q.size() != 0 && !p;
        if (pp) void'(q.pop_front());
        if (acc && r != 0) q.push_back('{r, d});
        @(negedge Clk);
    endtask

    task automatic async_reset();
        #2;
        Reset_n = 1'b0;
        #1;
        q.delete();
        chk("rst_reg_write", 32'(RegWrite), 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        #1;
        LookupReg1 = 5'd3;
        #1;
        check_model();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 0);
        chk("lat_reg_write", 32'(RegWrite), 32'd1);
        chk("lat_write_register", 32'(WriteRegister), 32'd5);
        chk("lat_write_data", WriteData, 32'hDEADBEEF);
        step(0, 0, 0, 0, 5'd5, 0);
        chk("drained_empty", 32'(Empty), 32'd1);
        step(1, 5'd0, 32'h1234, 0, 0, 0);
        chk("r0_count", 32'(Count), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i * 'h11), 1, 5'd2, 5'd4);
        chk("pause_full_count", 32'(Count), 32'd4);
        step(1, 5'd9, 32'h99, 1, 5'd9, 0);
        chk("pause_full_ready", 32'(InReady), 32'd0);
        step(0, 0, 0, 0, 5'd1, 5'd3);
        chk("release_ready", 32'(InReady), 32'd1);
        repeat (4) step(0, 0, 0, 0, 5'd3, 5'd4);
        step(1, 5'd7, 32'hA, 1, 0, 0);
        step(1, 5'd7, 32'hB, 1, 0, 0);
        step(0, 0, 0, 1, 5'd7, 5'd8);
        chk("fwd7_data", FwdData1, 32'hB);
        chk("fwd8_hit", 32'(FwdHit2), 32'd0);
        step(0, 0, 0, 1, 5'd0, 5'd7);
        chk("fwd0_hit", 32'(FwdHit1), 32'd0);
        chk("fwd7_data2", FwdData2, 32'hB);
        repeat (3) step(0, 0, 0, 0, 5'd7, 0);
        for (int i = 0; i < 4; i++) step(1, 5'(20 + i), 32'(i + 100), 1, 0, 0);
        step(1, 5'd10, 32'hAA, 0, 5'd10, 5'd23);
        chk("no_pass_count", 32'(Count), 32'd3);
        repeat (4) step(0, 0, 0, 0, 5'd10, 0);
        step(1, 5'd11, 32'h111, 1, 0, 0);
        step(1, 5'd12, 32'h222, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 5'(13 + i), 32'(i + 'h300), 0, 5'(13 + i), 5'(12 + i));
            chk("stream_count", 32'(Count), 32'd2);
        end
        repeat (3) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 5'(1 + i), 32'(i + 'h50), 1, 0, 0);
        Pause = 1'b0;
        async_reset();
        repeat (3) step(0, 0, 0, 0, 5'd1, 5'd2);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
